booth_pp_gen_64: RTL and testbench



---
 rtl/booth_pp_gen_64.sv | 113 +++++++++++
 tb/tb_booth_pp_gen_64.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_gen_64.sv
// Radix-4 Booth encoder and partial-product generator for a signed WIDTHxWIDTH multiply.
// Builds NPP rows, PP_PER_CYCLE per cycle, into a bank held behind a valid/ready handshake.
module booth_pp_gen_64 #(
  parameter int WIDTH        = 64,
  parameter int PP_PER_CYCLE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*WIDTH-1:0]   pp_flat
);

  localparam int NPP = WIDTH / 2;
  localparam int RW  = 2 * WIDTH;
  localparam int NG  = NPP / PP_PER_CYCLE;
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int KW  = $clog2(NPP);

  // Handshake: an operand pair transfers on a clock edge where in_valid && in_ready;
  // the bank transfers on an edge where out_valid && out_ready. Neither ready
  // depends combinationally on any input.
  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

  state_t          state;
  logic [GW-1:0]   grp;
  logic [WIDTH-1:0] a_r, b_r;
  logic [RW-1:0]   bank [NPP];

  logic [WIDTH:0]  b_ext;
  logic [RW-1:0]   a_sx;
  logic [RW-1:0]   gen_row [PP_PER_CYCLE];
  logic [KW-1:0]   gen_idx [PP_PER_CYCLE];
  logic [2:0]      trip    [PP_PER_CYCLE];
  logic [RW-1:0]   mag     [PP_PER_CYCLE];
  logic            neg     [PP_PER_CYCLE];

  assign in_ready = (state == IDLE);

  // b_ext[0] supplies the implicit b_r[-1] = 0 of the lowest triplet.
  always_comb begin
    b_ext = {b_r, 1'b0};
    a_sx  = {{WIDTH{a_r[WIDTH-1]}}, a_r};
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      gen_idx[j] = KW'(int'(grp) * PP_PER_CYCLE + j);
      trip[j]    = b_ext[2*(int'(grp) * PP_PER_CYCLE + j) +: 3];
      mag[j]     = '0;
      neg[j]     = 1'b0;
      case (trip[j])
        3'b001, 3'b010: mag[j] = a_sx;
        3'b011:         mag[j] = a_sx << 1;
        3'b100: begin
          mag[j] = a_sx << 1;
          neg[j] = 1'b1;
        end
        3'b101, 3'b110: begin
          mag[j] = a_sx;
          neg[j] = 1'b1;
        end
        default: mag[j] = '0;
      endcase
      // Full two's-complement negation inside the row: no correction row downstream.
      gen_row[j] = (neg[j] ? (~mag[j] + RW'(1)) : mag[j])
                   << (2 * (int'(grp) * PP_PER_CYCLE + j));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grp       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NPP; i++) bank[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            grp   <= '0;
            state <= GEN;
          end
        end
        GEN: begin
          for (int j = 0; j < PP_PER_CYCLE; j++) bank[gen_idx[j]] <= gen_row[j];
          grp <= grp + GW'(1);
          if (grp == GW'(NG - 1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NPP; k++) begin : g_flat
    assign pp_flat[k*RW +: RW] = bank[k];
  end

endmodule

// File: tb/tb_booth_pp_gen_64.sv
// Bench for booth_pp_gen_64: directed latency/boundary cases plus random operands
// checked by a scoreboard against an arithmetic Booth model and the signed product.
module tb_booth_pp_gen_64;

  localparam int W   = 64;
  localparam int NPP = 32;
  localparam int RW  = 128;
  localparam int BW  = W * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] pp_flat;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;  // 0: held low, 1: held high, 2: random

  logic [RW-1:0] exp_q [$];
  logic [BW-1:0] bank_q [$];

  booth_pp_gen_64 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .pp_flat(pp_flat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always begin
    @(posedge clk);
    #2;
    out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  // reference model: digit_k = -2*b[2k+1] + b[2k] + b[2k-1], row_k = digit_k * a * 4^k
  function automatic logic [BW-1:0] model_bank(input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [BW-1:0] bk;
    logic signed [RW-1:0] sa, row;
    int d, lo;
    sa = signed'({{W{ma[W-1]}}, ma});
    for (int k = 0; k < NPP; k++) begin
      lo  = (k == 0) ? 0 : int'(mb[2*k-1]);
      d   = -2 * int'(mb[2*k+1]) + int'(mb[2*k]) + lo;
      row = sa * d;
      for (int s = 0; s < k; s++) row = row * 4;
      bk[k*RW +: RW] = row;
    end
    return bk;
  endfunction

  function automatic logic [RW-1:0] model_prod(input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic signed [RW-1:0] sa, sb;
    sa = signed'({{W{ma[W-1]}}, ma});
    sb = signed'({{W{mb[W-1]}}, mb});
    return sa * sb;
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] got, input logic [RW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic chk_bank(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] want);
    int bad;
    bad = -1;
    n_checks++;
    for (int k = NPP - 1; k >= 0; k--)
      if (got[k*RW +: RW] !== want[k*RW +: RW]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, bad + 1,
               got[bad*RW +: RW], want[bad*RW +: RW]);
    end
  endtask

  // driver
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb);
    int n;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", RW'(n >= 300), '0);
    exp_q.push_back(model_prod(ta, tb));
    bank_q.push_back(model_bank(ta, tb));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", RW'(exp_q.size()), '0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_bank: got a bank with empty expected queue");
      end else begin
        logic [RW-1:0] want, sum;
        logic [BW-1:0] wb;
        want = exp_q.pop_front();
        wb   = bank_q.pop_front();
        chk_bank("bank_rows", pp_flat, wb);
        sum = '0;
        for (int k = 0; k < NPP; k++) sum = sum + pp_flat[k*RW +: RW];
        chk("row_sum", sum, want);
      end
    end
  end

  // stimulus
  initial begin
    int lat;
    logic [W-1:0] ha, hb;
    logic [BW-1:0] hold_bank;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", RW'(out_valid), '0);
    chk("rst_in_ready", RW'(in_ready), RW'(1));
    chk_bank("rst_bank", pp_flat, '0);

    // reset during GEN aborts and clears the partial bank
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 64'd3;
    b = 64'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midgen_rst_out_valid", RW'(out_valid), '0);
    chk("midgen_rst_in_ready", RW'(in_ready), RW'(1));
    chk_bank("midgen_rst_bank", pp_flat, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 3 * 5: latency, rows and ready return
    send(64'd3, 64'd5);
    wait_valid(lat);
    chk("latency", RW'(lat), RW'(4));
    chk("r1_3x5", pp_flat[0 +: RW], RW'(3));
    chk("r2_3x5", pp_flat[RW +: RW], RW'(12));
    @(posedge clk);
    #1;
    chk("in_ready_after_hs", RW'(in_ready), RW'(1));
    chk("out_valid_after_hs", RW'(out_valid), '0);

    // -1 * -1
    send('1, '1);
    wait_valid(lat);
    chk("r1_m1", pp_flat[0 +: RW], RW'(1));
    chk("r2_m1", pp_flat[RW +: RW], '0);
    wait_drain();

    // most negative multiplicand with digit -2
    send(64'h8000_0000_0000_0000, 64'd2);
    wait_valid(lat);
    chk("r1_min", pp_flat[0 +: RW], 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    chk("r2_min", pp_flat[RW +: RW], 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0000);
    wait_drain();

    // stall in HOLD while new operands are offered
    ready_mode = 0;
    ha = 64'h0123_4567_89AB_CDEF;
    hb = 64'hFEDC_BA98_7654_3211;
    hold_bank = model_bank(ha, hb);
    send(ha, hb);
    wait_valid(lat);
    chk("hold_latency", RW'(lat), RW'(4));
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(posedge clk);
      #1;
      chk_bank("hold_stable", pp_flat, hold_bank);
      chk("hold_in_ready", RW'(in_ready), '0);
      chk("hold_out_valid", RW'(out_valid), RW'(1));
    end
    in_valid = 1'b0;
    ready_mode = 1;
    @(posedge clk);
    #1;
    ready_mode = 0;
    chk("pulse_in_ready", RW'(in_ready), RW'(1));
    chk("pulse_out_valid", RW'(out_valid), '0);
    ready_mode = 1;
    send(64'd7, 64'hFFFF_FFFF_FFFF_FFF9);
    wait_drain();

    // random operands with random downstream stalls
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      send(pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
